// File: rtl/vga_anim_timing.sv
// vga_anim_timing
//   640x480@60 Hz raster generator with a per-frame sprite pose index.
//
//   Ports
//     vga_clk       in   pixel clock, sole clock
//     reset_n       in   synchronous active-low reset
//     anim_en       in   1 = pose advances at frame ends, 0 = frozen
//     anim_restart  in   synchronous, forces pose 0 and clears the hold count
//     hs, vs        out  active-low syncs
//     blank         out  1 = visible pixel (draw enable)
//     DrawX, DrawY  out  raster counters
//     frame_end     out  one-cycle pulse on the last clock of a frame
//     sprite_frame  out  pose index, stable for a whole frame
module vga_anim_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int ANIM_FRAMES = 5,
  parameter int ANIM_HOLD   = 6
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       anim_en,
  input  logic       anim_restart,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_end,
  output logic [2:0] sprite_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [2:0] LAST_POSE = 3'(ANIM_FRAMES - 1);
  localparam logic [5:0] LAST_HOLD = 6'(ANIM_HOLD - 1);

  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       h_wrap;
  logic       hs_next;
  logic       vs_next;
  logic       blank_next;
  logic       fe_next;
  logic [5:0] hold_cnt;

  // Decodes are taken from the next counter values so the registered
  // strobes line up with the DrawX/DrawY they are registered alongside.
  always_comb begin
    h_wrap  = (DrawX == H_LAST);
    hc_next = h_wrap ? '0 : DrawX + 10'd1;
    vc_next = DrawY;
    if (h_wrap) begin
      vc_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
    end
    hs_next    = !((hc_next >= HS_START) && (hc_next < HS_END));
    vs_next    = !((vc_next >= VS_START) && (vc_next < VS_END));
    blank_next = (hc_next < H_VIS) && (vc_next < V_VIS);
    fe_next    = (hc_next == H_LAST) && (vc_next == V_LAST);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX     <= '0;
      DrawY     <= '0;
      hs        <= 1'b1;
      vs        <= 1'b1;
      blank     <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      DrawX     <= hc_next;
      DrawY     <= vc_next;
      hs        <= hs_next;
      vs        <= vs_next;
      blank     <= blank_next;
      frame_end <= fe_next;
    end
  end

  // Advancing on the edge that ends a frame makes the new pose appear
  // together with DrawX = DrawY = 0.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hold_cnt     <= '0;
      sprite_frame <= '0;
    end else if (anim_restart) begin
      hold_cnt     <= '0;
      sprite_frame <= '0;
    end else if (frame_end && anim_en) begin
      if (hold_cnt == LAST_HOLD) begin
        hold_cnt     <= '0;
        sprite_frame <= (sprite_frame == LAST_POSE) ? '0 : sprite_frame + 3'd1;
      end else begin
        hold_cnt <= hold_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_anim_timing.sv
// tb_vga_anim_timing
//   Two instances share clock and controls: one with the nominal 640x480
//   timing, one shrunk to a 24x10 raster so many frames fit in a short run.
//   A reference model derives every output from the clock count since reset
//   and the number of enabled frame ends since the last restart.
module tb_vga_anim_timing;

  localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 2;
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;   // 24
  localparam int SVT = SVA + SVF + SVS + SVB;   // 10
  localparam int SFR = SHT * SVT;               // 240 clocks per frame
  localparam int FHT = 800, FVT = 525;
  localparam int B   = 8;                       // frame index of the animation restart

  logic       vga_clk;
  logic       reset_n;
  logic       anim_en;
  logic       anim_restart;

  logic       hs, vs, blank, frame_end;
  logic [9:0] DrawX, DrawY;
  logic [2:0] sprite_frame;

  logic       f_hs, f_vs, f_blank, f_fe;
  logic [9:0] f_x, f_y;
  logic [2:0] f_sprite;

  vga_anim_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .ANIM_FRAMES(5), .ANIM_HOLD(6)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .anim_en(anim_en),
    .anim_restart(anim_restart), .hs(hs), .vs(vs), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .frame_end(frame_end),
    .sprite_frame(sprite_frame)
  );

  vga_anim_timing dut_full (
    .vga_clk(vga_clk), .reset_n(reset_n), .anim_en(anim_en),
    .anim_restart(anim_restart), .hs(f_hs), .vs(f_vs), .blank(f_blank),
    .DrawX(f_x), .DrawY(f_y), .frame_end(f_fe),
    .sprite_frame(f_sprite)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int    checks = 0;
  int    errors = 0;
  longint t_m = 0;
  int    steps_s = 0;
  int    steps_f = 0;
  bit    mvalid = 1'b0;

  typedef struct {
    longint     t;
    logic       hs;
    logic       blank;
    logic [9:0] x;
    logic [9:0] y;
  } hvec_t;

  hvec_t tbl[$];

  function automatic bit is_fe(longint t, int ht, int vt);
    return (t % (ht * vt)) == longint'(ht * vt - 1);
  endfunction

  function automatic logic [26:0] exp_out(longint t, int steps,
      int ha, int hf, int hsy, int hb, int va, int vf, int vsy, int vb,
      int nf, int nh);
    int     ht = ha + hf + hsy + hb;
    int     vt = va + vf + vsy + vb;
    longint x  = t % ht;
    longint y  = (t / ht) % vt;
    logic   h  = !(x >= ha + hf && x < ha + hf + hsy);
    logic   v  = !(y >= va + vf && y < va + vf + vsy);
    logic   bl = (x < ha) && (y < va);
    logic   fe = (x == ht - 1) && (y == vt - 1);
    int     pose = (steps / nh) % nf;
    return {h, v, bl, fe, 10'(x), 10'(y), 3'(pose)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0d", name, act, exp, t_m);
    end
  endtask

  // Model advance uses the inputs the DUT samples on the coming edge.
  task automatic tick();
    if (!reset_n) begin
      t_m = 0; steps_s = 0; steps_f = 0; mvalid = 1'b1;
    end else if (mvalid) begin
      if (anim_restart) begin
        steps_s = 0; steps_f = 0;
      end else if (anim_en) begin
        if (is_fe(t_m, SHT, SVT)) steps_s++;
        if (is_fe(t_m, FHT, FVT)) steps_f++;
      end
      t_m++;
    end
    @(posedge vga_clk);
    @(negedge vga_clk);
    if (mvalid) begin
      chk("small_cycle", {5'd0, hs, vs, blank, frame_end, DrawX, DrawY, sprite_frame},
          {5'd0, exp_out(t_m, steps_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 5, 6)});
      chk("full_cycle", {5'd0, f_hs, f_vs, f_blank, f_fe, f_x, f_y, f_sprite},
          {5'd0, exp_out(t_m, steps_f, 640, 16, 96, 48, 480, 10, 2, 33, 5, 6)});
    end
  endtask

  task automatic run_to(longint target);
    while (t_m < target) tick();
  endtask

  function automatic longint fstart(int k);
    return longint'((B + k) * SFR);
  endfunction

  initial begin
    int     hs_lo, bl_lo, vs_lo, bl_hi, fe_cnt;
    logic [19:0] fe_pos;
    longint fs, tgt;

    reset_n = 1'b0; anim_en = 1'b0; anim_restart = 1'b0;
    @(negedge vga_clk);

    // Reset with both animation controls active: reset must win.
    anim_en = 1'b1; anim_restart = 1'b1;
    repeat (3) tick();
    chk("rst_drawx", 32'(DrawX), 32'd0);
    chk("rst_drawy", 32'(DrawY), 32'd0);
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd1);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_frame_end", 32'(frame_end), 32'd0);
    chk("rst_sprite", 32'(sprite_frame), 32'd0);
    anim_restart = 1'b0;

    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("release_count", 32'(DrawX), 32'(i));
    end

    // Line 0 of the nominal raster.
    tbl.push_back('{4,   1'b1, 1'b1, 10'd4,   10'd0});
    tbl.push_back('{100, 1'b1, 1'b1, 10'd100, 10'd0});
    tbl.push_back('{639, 1'b1, 1'b1, 10'd639, 10'd0});
    tbl.push_back('{640, 1'b1, 1'b0, 10'd640, 10'd0});
    tbl.push_back('{655, 1'b1, 1'b0, 10'd655, 10'd0});
    tbl.push_back('{656, 1'b0, 1'b0, 10'd656, 10'd0});
    tbl.push_back('{700, 1'b0, 1'b0, 10'd700, 10'd0});
    tbl.push_back('{751, 1'b0, 1'b0, 10'd751, 10'd0});
    tbl.push_back('{752, 1'b1, 1'b0, 10'd752, 10'd0});
    tbl.push_back('{799, 1'b1, 1'b0, 10'd799, 10'd0});
    foreach (tbl[i]) begin
      run_to(tbl[i].t);
      chk("full_line0", {10'd0, f_hs, f_blank, f_x, f_y},
          {10'd0, tbl[i].hs, tbl[i].blank, tbl[i].x, tbl[i].y});
    end

    hs_lo = 0; bl_lo = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (i == 0) chk("full_wrap_y1", {12'd0, f_x, f_y}, {12'd0, 10'd0, 10'd1});
      if (!f_hs) hs_lo++;
      if (!f_blank) bl_lo++;
    end
    chk("full_hs_low_clocks", 32'(hs_lo), 32'd96);
    chk("full_blank_low_clocks", 32'(bl_lo), 32'd160);
    tick();
    chk("full_wrap_y2", {12'd0, f_x, f_y}, {12'd0, 10'd0, 10'd2});

    // One whole frame of the small raster: frame 7.
    run_to(7 * SFR - 1);
    vs_lo = 0; bl_hi = 0; fe_cnt = 0; fe_pos = '0;
    for (int i = 0; i < SFR; i++) begin
      tick();
      if (!vs) vs_lo++;
      if (blank) bl_hi++;
      if (frame_end) begin
        fe_cnt++;
        fe_pos = {DrawX, DrawY};
      end
    end
    chk("small_vs_low_clocks", 32'(vs_lo), 32'(SVS * SHT));
    chk("small_visible_clocks", 32'(bl_hi), 32'(SHA * SVA));
    chk("small_frame_end_count", 32'(fe_cnt), 32'd1);
    chk("small_frame_end_pos", 32'(fe_pos), {12'd0, 10'd23, 10'd9});

    // Restart on the frame_end cycle; animation counted from here.
    anim_restart = 1'b1;
    tick();
    anim_restart = 1'b0;
    chk("restart_pose", 32'(sprite_frame), 32'd0);

    run_to(fstart(5));       chk("pose_after5", 32'(sprite_frame), 32'd0);
    run_to(fstart(6) - 1);   chk("pose_before6", 32'(sprite_frame), 32'd0);
    run_to(fstart(6));       chk("pose_after6", 32'(sprite_frame), 32'd1);
    run_to(fstart(24));      chk("pose_after24", 32'(sprite_frame), 32'd4);
    run_to(fstart(30) - 1);  chk("pose_before30", 32'(sprite_frame), 32'd4);
    run_to(fstart(30));      chk("pose_after30", 32'(sprite_frame), 32'd0);
    run_to(fstart(36));      chk("pose_after36", 32'(sprite_frame), 32'd1);

    run_to(fstart(36) + 5);
    anim_en = 1'b0;
    run_to(fstart(46) + 5);
    chk("pose_frozen", 32'(sprite_frame), 32'd1);
    anim_en = 1'b1;

    // 12 enabled ends after the freeze: 36 + 12 = 48 -> pose 3.
    run_to(fstart(59) - 1);
    chk("pose_before_restart", 32'(sprite_frame), 32'd3);
    chk("fe_at_restart", 32'(frame_end), 32'd1);
    anim_restart = 1'b1;
    tick();
    anim_restart = 1'b0;
    chk("restart_wins", 32'(sprite_frame), 32'd0);
    run_to(fstart(65) - 1);  chk("post_restart_hold", 32'(sprite_frame), 32'd0);
    run_to(fstart(65));      chk("post_restart_adv", 32'(sprite_frame), 32'd1);

    // Random enable / restart activity, checked by the model every cycle.
    for (int i = 0; i < 20 * SFR; i++) begin
      if ($urandom_range(0, 99) == 0) anim_en = 1'($urandom_range(0, 1));
      anim_restart = ($urandom_range(0, 399) == 0);
      tick();
    end
    anim_restart = 1'b0;
    anim_en = 1'b1;

    // Mid-frame restart then mid-frame reset with pose 2 showing.
    run_to(t_m + 37);
    anim_restart = 1'b1;
    tick();
    anim_restart = 1'b0;
    fs  = ((t_m / SFR) + 1) * SFR;
    tgt = fs + 11 * SFR + 5 * SHT + 10;
    run_to(tgt);
    chk("pre_reset_pos", {12'd0, DrawX, DrawY}, {12'd0, 10'd10, 10'd5});
    chk("pre_reset_pose", 32'(sprite_frame), 32'd2);
    reset_n = 1'b0;
    tick();
    chk("midrst_outputs", {5'd0, hs, vs, blank, frame_end, DrawX, DrawY, sprite_frame},
        {5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'd0});
    chk("midrst_full_xy", {12'd0, f_x, f_y}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("midrst_release", {12'd0, DrawX, DrawY}, {12'd0, 10'd1, 10'd0});
    run_to(2 * SFR + 3);
    chk("midrst_pose_after2", 32'(sprite_frame), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
